// File: rtl/tdm_demux_rx_pkg.sv
// Shared definitions for the TDM receive path: FSM state encoding and slot-width helper.
package tdm_demux_rx_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic int slot_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Modulo-CH slot counter with enable, synchronous load-to-1 (resync) and wrap flag.
module tdm_slot_ctr
    import tdm_demux_rx_pkg::*;
#(
    parameter int CH = 4,
    localparam int SW = slot_w(CH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load,
    output logic [SW-1:0] slot,
    output logic          wrap
);

    localparam logic [SW-1:0] LAST = SW'(CH - 1);

    assign wrap = (slot == LAST);

    // Load lands on slot 1 because the cycle that loads also captures slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (load) begin
            slot <= SW'(1);
        end else if (en) begin
            slot <= wrap ? '0 : slot + SW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM lane receiver: hunts for a sync strobe, then rebuilds CH-channel frames from the serial lane.
module tdm_demux_rx
    import tdm_demux_rx_pkg::*;
#(
    parameter int CH = 4,
    parameter int W  = 1,
    localparam int SW = slot_w(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            sync,
    input  logic [W-1:0]    din,
    output logic [SW-1:0]   slot,
    output logic [CH*W-1:0] dout,
    output logic            dout_valid,
    output logic            locked,
    output logic            sync_err
);

    state_t              state;
    logic [CH-1:0][W-1:0] shadow;
    logic                wrap;
    logic                hunt_hit;
    logic                resync;

    assign hunt_hit = en & sync & (state == ST_HUNT);
    assign resync   = en & sync & (state == ST_LOCKED) & (slot != '0);

    tdm_slot_ctr #(.CH(CH)) u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en & (state == ST_LOCKED)),
        .load  (hunt_hit | resync),
        .slot  (slot),
        .wrap  (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HUNT;
            shadow     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
            if (en) begin
                case (state)
                    ST_HUNT: begin
                        if (sync) begin
                            shadow[0] <= din;
                            state     <= ST_LOCKED;
                            locked    <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        // A misplaced sync wins over a last-slot capture.
                        if (resync) begin
                            shadow    <= '0;
                            shadow[0] <= din;
                            sync_err  <= 1'b1;
                        end else begin
                            shadow[slot] <= din;
                            if (wrap) begin
                                dout       <= {din, shadow[CH-2:0]};
                                dout_valid <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Scoreboard bench for tdm_demux_rx (CH=4, W=1): stimulus queues expected frames/errors, monitor checks.
module tb_tdm_demux_rx;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       sync;
    logic [0:0] din;
    logic [1:0] slot;
    logic [3:0] dout;
    logic       dout_valid;
    logic       locked;
    logic       sync_err;

    typedef struct {
        logic [3:0] d;
        int         c;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    tdm_demux_rx #(.CH(4), .W(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sync       (sync),
        .din        (din),
        .slot       (slot),
        .dout       (dout),
        .dout_valid (dout_valid),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; the next rising edge consumes them.
    task automatic slot_in(input logic e, input logic s, input logic d);
        @(negedge clk);
        en   = e;
        sync = s;
        din  = d;
    endtask

    task automatic push_frame(input logic [3:0] f);
        exp_t e;
        e.d = f;
        e.c = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        err_q.push_back(cyc + 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en    = 1'b0;
        sync  = 1'b0;
        din   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every output pulse must match the head of its queue, on the expected cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL dout_valid_unexpected: dout=%h at cyc %0d, none expected", dout, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (dout !== e.d || cyc != e.c) begin
                        n_bad++;
                        $display("FAIL frame: got dout=%h at cyc %0d, expected %h at cyc %0d",
                                 dout, cyc, e.d, e.c);
                    end
                end
            end else if (exp_q.size() != 0 && cyc >= exp_q[0].c) begin
                exp_t e;
                e = exp_q.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL frame_missing: no dout_valid at cyc %0d, expected %h", cyc, e.d);
            end
            if (sync_err) begin
                n_vec++;
                if (err_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sync_err_unexpected: pulse at cyc %0d, none expected", cyc);
                end else begin
                    int c;
                    c = err_q.pop_front();
                    if (cyc != c) begin
                        n_bad++;
                        $display("FAIL sync_err_timing: got cyc %0d, expected cyc %0d", cyc, c);
                    end
                end
            end else if (err_q.size() != 0 && cyc >= err_q[0]) begin
                int c;
                c = err_q.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL sync_err_missing: no pulse at cyc %0d, expected at %0d", cyc, c);
            end
        end
    end

    logic [3:0] frames [3];

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        sync  = 1'b0;
        din   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: async reset mid-frame
        slot_in(1, 1, 1);
        slot_in(1, 0, 1);
        check("pre_reset_locked", int'(locked), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_slot", int'(slot), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_sync_err", int'(sync_err), 0);
        @(negedge clk);
        en    = 1'b0;
        sync  = 1'b0;
        rst_n = 1'b1;

        // 2: basic frame 1,0,1,0 -> 5
        slot_in(1, 1, 1);
        slot_in(1, 0, 0);
        check("basic_locked", int'(locked), 1);
        check("basic_slot1", int'(slot), 1);
        slot_in(1, 0, 1);
        slot_in(1, 0, 0);
        push_frame(4'h5);
        slot_in(0, 0, 0);
        slot_in(0, 0, 0);
        check("basic_slot_wrap", int'(slot), 0);

        // 3: hunt ignores data without sync
        do_reset();
        for (int i = 0; i < 6; i++) slot_in(1, 0, logic'(i[0]));
        slot_in(1, 1, 1);
        check("hunt_locked", int'(locked), 0);
        check("hunt_slot", int'(slot), 0);
        slot_in(1, 0, 1);
        slot_in(1, 0, 1);
        slot_in(1, 0, 1);
        push_frame(4'hF);
        slot_in(0, 0, 0);

        // 4: en gaps, frame 0,1,1,0 -> 6; sync during gaps ignored
        slot_in(1, 1, 0);
        slot_in(0, 1, 1);
        slot_in(0, 0, 1);
        check("gap_slot_hold", int'(slot), 1);
        slot_in(1, 0, 1);
        slot_in(0, 1, 0);
        slot_in(0, 0, 0);
        check("gap_slot_hold2", int'(slot), 2);
        slot_in(1, 0, 1);
        slot_in(0, 1, 1);
        slot_in(0, 0, 1);
        slot_in(1, 0, 0);
        push_frame(4'h6);
        slot_in(0, 0, 0);

        // 5: misplaced sync at slot 2 restarts the frame -> A
        slot_in(1, 1, 1);
        slot_in(1, 0, 1);
        slot_in(1, 1, 0);
        push_err();
        slot_in(1, 0, 1);
        check("resync_slot", int'(slot), 1);
        slot_in(1, 0, 0);
        slot_in(1, 0, 1);
        push_frame(4'hA);
        slot_in(0, 0, 0);

        // misplaced sync on the last slot: no frame, error only
        slot_in(1, 1, 1);
        slot_in(1, 0, 1);
        slot_in(1, 0, 1);
        slot_in(1, 1, 1);
        push_err();
        slot_in(0, 0, 0);
        check("last_resync_slot", int'(slot), 1);

        // 6: back-to-back frames, sync only on the first
        do_reset();
        frames[0] = 4'h5;
        frames[1] = 4'h3;
        frames[2] = 4'hC;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                slot_in(1, (f == 0 && k == 0), frames[f][k]);
                if (k == 3) push_frame(frames[f]);
            end
        end
        slot_in(0, 0, 0);
        repeat (4) @(negedge clk);

        check("exp_q_drained", exp_q.size(), 0);
        check("err_q_drained", err_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
